// File: rtl/imem_pkg.sv
// Shared types and address helpers for the instruction memory controller.
// The loader and fetch paths decode addresses through the same functions.
package imem_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } imem_state_e;

  localparam logic [31:0] IMEM_NOP_WORD = 32'h0000_0000;

  function automatic logic [31:0] imem_addr_index(
    input logic [31:0] addr,
    input logic        byte_mode
  );
    return byte_mode ? (addr >> 2) : addr;
  endfunction

  // Upper address bits must not alias onto the array, so compare full width.
  function automatic logic imem_addr_ok(
    input logic [31:0] addr,
    input logic        byte_mode,
    input int unsigned depth
  );
    logic [31:0] idx;
    idx = imem_addr_index(addr, byte_mode);
    return (idx < depth) && (!byte_mode || addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/imem_ram.sv
// DEPTH x DATA_W array, one sync write port and one sync read port.
// A same-cycle read and write to one index returns the old word.
module imem_ram
  import imem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      rdata_d = mem[raddr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/instruction_memory_ctrl.sv
// Instruction store with fetch/load handshakes, fault reporting
// and a clear sequencer that sweeps the array after reset.
module instruction_memory_ctrl
  import imem_pkg::*;
#(
  parameter int                DATA_W       = 32,
  parameter int                DEPTH        = 64,
  parameter int                PC_BYTE_ADDR = 0,
  parameter logic [DATA_W-1:0] NOP_WORD     = DATA_W'(IMEM_NOP_WORD)
) (
  input  logic              clk,
  input  logic              instruction_reset_n,
  input  logic              clear_req,
  input  logic              fetch_req,
  input  logic [31:0]       pc,
  output logic              fetch_ready,
  output logic [DATA_W-1:0] instruction,
  output logic              instruction_valid,
  output logic              fetch_fault,
  input  logic              load_we,
  input  logic [31:0]       load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_fault,
  output logic              busy
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic BYTE_MODE = (PC_BYTE_ADDR != 0);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  imem_state_e       state_q, state_d;
  logic [ADDR_W-1:0] clr_idx_q, clr_idx_d;
  logic              valid_q, valid_d;
  logic              fault_q, fault_d;
  logic              nop_sel_q, nop_sel_d;
  logic              load_fault_q, load_fault_d;

  logic              ready;
  logic              fetch_acc;
  logic              load_acc;
  logic              fetch_ok;
  logic              load_ok;
  logic [ADDR_W-1:0] fetch_idx;
  logic [ADDR_W-1:0] load_idx;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;

  assign fetch_ok  = imem_addr_ok(pc, BYTE_MODE, DEPTH);
  assign load_ok   = imem_addr_ok(load_addr, BYTE_MODE, DEPTH);
  assign fetch_idx = ADDR_W'(imem_addr_index(pc, BYTE_MODE));
  assign load_idx  = ADDR_W'(imem_addr_index(load_addr, BYTE_MODE));

  assign ready     = (state_q == ST_IDLE) && !clear_req;
  assign fetch_acc = fetch_req && ready;
  assign load_acc  = load_we && ready;
  assign ram_re    = fetch_acc && fetch_ok;

  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    ram_we    = 1'b0;
    ram_waddr = load_idx;
    ram_wdata = load_data;
    unique case (state_q)
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = clr_idx_q;
        ram_wdata = '0;
        if (clr_idx_q == LAST_IDX) begin
          state_d   = ST_IDLE;
          clr_idx_d = '0;
        end else begin
          clr_idx_d = clr_idx_q + ADDR_W'(1);
        end
      end
      ST_IDLE: begin
        if (clear_req) begin
          state_d   = ST_CLEAR;
          clr_idx_d = '0;
        end else begin
          ram_we = load_acc && load_ok;
        end
      end
    endcase
  end

  // nop_sel remembers whether the last accepted fetch faulted,
  // so the held instruction stays NOP until the next accept.
  always_comb begin
    valid_d      = fetch_acc;
    fault_d      = fetch_acc && !fetch_ok;
    nop_sel_d    = nop_sel_q;
    load_fault_d = load_acc && !load_ok;
    if (fetch_acc) begin
      nop_sel_d = !fetch_ok;
    end
  end

  always_ff @(posedge clk or negedge instruction_reset_n) begin
    if (!instruction_reset_n) begin
      state_q      <= ST_CLEAR;
      clr_idx_q    <= '0;
      valid_q      <= 1'b0;
      fault_q      <= 1'b0;
      nop_sel_q    <= 1'b0;
      load_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_idx_q    <= clr_idx_d;
      valid_q      <= valid_d;
      fault_q      <= fault_d;
      nop_sel_q    <= nop_sel_d;
      load_fault_q <= load_fault_d;
    end
  end

  imem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (instruction_reset_n),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (fetch_idx),
    .rdata (ram_rdata)
  );

  assign fetch_ready       = ready;
  assign load_ready        = ready;
  assign instruction       = nop_sel_q ? NOP_WORD : ram_rdata;
  assign instruction_valid = valid_q;
  assign fetch_fault       = fault_q;
  assign load_fault        = load_fault_q;
  assign busy              = (state_q == ST_CLEAR);

endmodule

// File: doc/instruction_memory_ctrl.md
Name: instruction_memory_ctrl

Overview:
- Parametrised successor to the team's instruction store: a 1-write/1-read synchronous instruction memory with a fetch handshake, a loader port, range and alignment fault reporting, and a hardware clear sequencer.
- Sits between the PC/fetch stage and the program loader.
- After reset, the clear sequencer sweeps the array to zero, one word per cycle. Fetch and load are blocked until the sweep completes.

Parameters:
- DATA_W, 32, instruction word width in bits.
- DEPTH, 64, number of words; any value ≥ 2.
- PC_BYTE_ADDR, 0, 1 = pc and load_addr are byte addresses (index = addr>>2, addr[1:0] must be 0); 0 = word addresses.
- NOP_WORD, 0, DATA_W value driven on instruction for a faulting fetch.
- ADDR_W (localparam), $clog2(DEPTH), internal index width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- instruction_reset_n  in  1  asynchronous active-low reset.
- clear_req  in  1  request a full clear sweep; sampled in IDLE.
- fetch_req  in  1  fetch request.
- pc  in  32  fetch address.
- fetch_ready  out  1  fetch accepted when fetch_req && fetch_ready.
- instruction  out  DATA_W  fetched word; holds between fetches.
- instruction_valid  out  1  one-cycle pulse, one cycle after an accepted fetch.
- fetch_fault  out  1  valid with instruction_valid; out-of-range or misaligned fetch.
- load_we  in  1  loader write request.
- load_addr  in  32  loader address.
- load_data  in  DATA_W  loader write data.
- load_ready  out  1  load accepted when load_we && load_ready.
- load_fault  out  1  one-cycle pulse, one cycle after an accepted load that was dropped.
- busy  out  1  high while in CLEAR.

Behaviour:
- Reset values (async, while instruction_reset_n=0):
  - state=CLEAR, clr_idx=0, busy=1.
  - instruction=0, instruction_valid=0, fetch_fault=0, load_fault=0.
  - Array contents are not reset directly; the sweep clears them.
- FSM states:
  - CLEAR: write 0 to array[clr_idx] each cycle and increment clr_idx. When clr_idx==DEPTH-1 is written, go to IDLE next cycle. A sweep takes exactly DEPTH cycles.
  - IDLE: if clear_req=1, go to CLEAR with clr_idx=0.
- Reset asserted mid-sweep restarts the sweep from index 0.
- Ready signals:
  - fetch_ready = load_ready = (state==IDLE) && !clear_req.
  - clear_req therefore wins over same-cycle fetch or load; those requests are not accepted.
- Index and validity:
  - Index = PC_BYTE_ADDR ? addr>>2 : addr.
  - An address is valid when index < DEPTH and, if PC_BYTE_ADDR=1, addr[1:0]==0.
- Fetch (latency 1):
  - On accept, the next cycle has instruction_valid=1.
  - Valid address: instruction = array[index], fetch_fault=0.
  - Invalid address: instruction = NOP_WORD, fetch_fault=1.
  - With no accept, instruction_valid=0 and fetch_fault=0; instruction holds its last value.
  - Back-to-back accepts produce a valid pulse every cycle.
- Load:
  - On accept with a valid address, array[index] = load_data at that edge.
  - Invalid address: no write, and load_fault=1 the next cycle.
- Simultaneous fetch and load to the same index in one cycle: both are accepted and the fetch returns the OLD word (read-before-write). The new word is visible to fetches accepted in later cycles.
- Upper pc/load_addr bits beyond the index range never alias: they produce a fault, not a wrap.

Decomposition:
- Package imem_pkg holds:
  - the state enum {CLEAR, IDLE};
  - the default NOP_WORD constant;
  - the address-to-index/validity function, shared with the loader.
- Sub-module imem_ram: DEPTH x DATA_W array with one synchronous write port and one synchronous read port, read-before-write. The controller muxes the write port between the clear sequencer and the loader.

Test Plan:
- Reset release with DEPTH=64: busy=1 and fetch_ready=0 for exactly 64 cycles, then busy=0. Fetching index 5 then returns 0 with fetch_fault=0.
- Word mode: load addr 3 = 0xDEADBEEF, then fetch pc=3 → one cycle later instruction=0xDEADBEEF, valid=1. With no further fetches, instruction holds the value.
- Same cycle: load addr 7 = 0x11111111 and fetch pc=7, where array[7]=0xAAAAAAAA → fetch returns 0xAAAAAAAA. A fetch of pc=7 the next cycle returns 0x11111111.
- Out-of-range fetch pc=64 → instruction=NOP_WORD, fetch_fault=1 for one cycle. Load to addr 100 → load_fault=1 for one cycle, array unchanged.
- PC_BYTE_ADDR=1: fetch pc=0x0C returns word 3. Fetch pc=0x0E → fetch_fault=1.
- clear_req during IDLE: the same-cycle fetch is refused (fetch_ready=0) and a 64-cycle sweep follows. Asserting instruction_reset_n=0 at sweep cycle 30 restarts the sweep, giving a full 64 busy cycles after release. All words read 0 afterwards.
